if_pc_fetch_stage: RTL and testbench

PC generation and IF/ID pipeline register for the 5-stage pipeline. Drives the byte address into the instruction memory and receives the 32-bit big-endian word it returns combinationally. Registers that word, with its PC+4, into the IF/ID latch consumed by decode. Handles load-use stalls, branch/jump redirects with flush, and a halt state.

---
 rtl/if_pc_fetch_stage.sv | 183 ++++++++++++++++++
 tb/tb_if_pc_fetch_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_pc_fetch_stage
//
// Program counter generation and IF/ID pipeline register for a 5-stage core.
// The PC register drives the instruction memory address directly; the memory
// answers combinationally with a 32-bit word. That word and its PC+4 are
// captured into the IF/ID latch on the next rising edge of clk_e.
//
// Control priority in RUN (highest first): redirect, halt_req, stall, fetch.
// A short BOOT state fetches the reset vector exactly once after reset. A
// HALT state freezes fetch until resume.
//
// Parameters:
//   RESET_PC    PC loaded on reset (word aligned)
//   IMEM_BYTES  instruction memory size in bytes; PC wraps modulo this value
//               (power of two, >= 8)
//   NOP_WORD    bubble instruction inserted on flush, boot and halt
//
// Ports:
//   clk_e         in   pipeline clock, rising edge
//   reset         in   asynchronous, active-high reset
//   stall         in   hold PC and IF/ID (load-use hazard)
//   redirect      in   branch taken / jump resolved, one-cycle pulse
//   redirect_pc   in   redirect target byte address
//   halt_req      in   stop fetching (level or pulse)
//   resume        in   leave HALT
//   pc            out  fetch address to instruction memory (PC register)
//   instr_in      in   instruction word returned for pc
//   if_id_instr   out  latched instruction for decode
//   if_id_pc4     out  latched, unwrapped PC+4 of that instruction
//   if_id_valid   out  1 = real instruction, 0 = bubble
//   halted        out  1 while in HALT
//   misalign_err  out  sticky flag: a redirect target had bits[1:0] != 0
// -----------------------------------------------------------------------------
module if_pc_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk_e,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  input  logic [31:0] instr_in,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign_err
);

  // Clearing every bit at or above log2(IMEM_BYTES) is the modulo for a
  // power-of-two memory size.
  localparam logic [31:0] PC_MASK = 32'(IMEM_BYTES) - 32'd1;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state_q,    state_d;
  logic [31:0] pc_q,       pc_d;
  logic [31:0] instr_q,    instr_d;
  logic [31:0] pc4_q,      pc4_d;
  logic        valid_q,    valid_d;
  logic        halted_q,   halted_d;
  logic        misalign_q, misalign_d;

  logic [31:0] pc_plus4;      // unwrapped, feeds if_id_pc4
  logic [31:0] pc_seq;        // wrapped, feeds the PC register
  logic [31:0] redir_target;  // aligned and wrapped redirect target
  logic        redir_misalign;

  assign pc_plus4       = pc_q + 32'd4;
  assign pc_seq         = pc_plus4 & PC_MASK;
  assign redir_target   = {redirect_pc[31:2], 2'b00} & PC_MASK;
  assign redir_misalign = (redirect_pc[1:0] != 2'b00);

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    unique case (state_q)
      ST_BOOT: begin
        // Fetch the reset vector once; control inputs are not yet honoured.
        instr_d = instr_in;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        pc_d    = pc_seq;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        if (redirect) begin
          // Wrong-path fetch is squashed; a redirect beats a stall because
          // the stalled instruction is on the wrong path anyway.
          pc_d    = redir_target;
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          if (redir_misalign) begin
            misalign_d = 1'b1;
          end
        end else if (halt_req) begin
          // PC is held so fetch resumes at the instruction not yet latched.
          instr_d = NOP_WORD;
          valid_d = 1'b0;
          state_d = ST_HALT;
        end else if (stall) begin
          // Hold everything (defaults already do so).
        end else begin
          instr_d = instr_in;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_seq;
        end
      end

      ST_HALT: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        if (redirect) begin
          pc_d = redir_target;
          if (redir_misalign) begin
            misalign_d = 1'b1;
          end
        end
        // A still-asserted halt_req keeps the stage parked even on resume.
        if (resume && !halt_req) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    halted_d = (state_d == ST_HALT);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_e or posedge reset) begin
    if (reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pc4_q      <= 32'd0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc4_q      <= pc4_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign if_id_instr  = instr_q;
  assign if_id_pc4    = pc4_q;
  assign if_id_valid  = valid_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_if_pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// Directed testbench for if_pc_fetch_stage (IMEM_BYTES = 32, 8 words).
// The instruction memory is a small array answering combinationally on pc.
// -----------------------------------------------------------------------------
module tb_if_pc_fetch_stage;

  logic        clk_e;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic [31:0] pc;
  logic [31:0] instr_in;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic        misalign_err;

  int err_cnt = 0;
  int chk_cnt = 0;
  int tick_no = 0;

  logic [31:0] mem [8];

  if_pc_fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .IMEM_BYTES(32),
    .NOP_WORD  (32'h0000_0000)
  ) dut (
    .clk_e       (clk_e),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc          (pc),
    .instr_in    (instr_in),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .misalign_err(misalign_err)
  );

  initial clk_e = 1'b0;
  always #5 clk_e = ~clk_e;

  assign instr_in = mem[pc[4:2]];

  function automatic logic [31:0] w(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h0000_0101;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk_e);
    #1;
    tick_no++;
    $display("tick %0d: pc=%h instr=%h pc4=%h valid=%b halted=%b mis=%b",
             tick_no, pc, if_id_instr, if_id_pc4, if_id_valid, halted, misalign_err);
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4, input logic e_valid);
    check_eq({tag, ".pc"},    pc,          e_pc);
    check_eq({tag, ".instr"}, if_id_instr, e_instr);
    check_eq({tag, ".pc4"},   if_id_pc4,   e_pc4);
    check_eq({tag, ".valid"}, 32'(if_id_valid), 32'(e_valid));
  endtask

  task automatic check_reset_state(input string tag);
    check_ifid(tag, 32'h0, 32'h0, 32'h0, 1'b0);
    check_eq({tag, ".halted"},   32'(halted),       32'd0);
    check_eq({tag, ".misalign"}, 32'(misalign_err), 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) mem[k] = w(k);
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt_req    = 1'b0;
    resume      = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_e);
    #1;
    check_reset_state("rst");
    reset = 1'b0;

    // 1. Free-running fetch from reset: BOOT edge then sequential
    for (int k = 1; k <= 6; k++) begin
      tick();
      check_ifid($sformatf("seq%0d", k), 32'(4 * k), w(k - 1), 32'(4 * k), 1'b1);
    end

    // 2. Stall at pc=8
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    tick();
    check_ifid("pre_stall", 32'd8, w(1), 32'd8, 1'b1);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_ifid($sformatf("stall%0d", k), 32'd8, w(1), 32'd8, 1'b1);
    end
    stall = 1'b0;
    tick();
    check_ifid("stall_rel", 32'd12, w(2), 32'd12, 1'b1);

    // 3. Return to pc=8, then redirect together with stall
    redirect = 1'b1; redirect_pc = 32'd8;
    tick();
    check_ifid("redir8", 32'd8, 32'h0, 32'd12, 1'b0);
    stall = 1'b1; redirect_pc = 32'd16;
    tick();
    check_eq("redir_stall.pc",    pc,                32'd16);
    check_eq("redir_stall.instr", if_id_instr,       32'h0);
    check_eq("redir_stall.valid", 32'(if_id_valid),  32'd0);
    stall = 1'b0; redirect = 1'b0;
    tick();
    check_ifid("redir_tgt", 32'd20, w(4), 32'd20, 1'b1);

    // 4. Wrap at IMEM_BYTES and misaligned redirect
    tick();
    check_ifid("wrap_a", 32'd24, w(5), 32'd24, 1'b1);
    tick();
    check_ifid("wrap_b", 32'd28, w(6), 32'd28, 1'b1);
    tick();
    check_ifid("wrap_c", 32'd0, w(7), 32'd32, 1'b1);
    check_eq("wrap_c.mis", 32'(misalign_err), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_0006;
    tick();
    check_eq("misal.pc",    pc,               32'd4);
    check_eq("misal.valid", 32'(if_id_valid), 32'd0);
    check_eq("misal.flag",  32'(misalign_err), 32'd1);
    redirect = 1'b0;
    tick();
    check_ifid("misal_a", 32'd8, w(1), 32'd8, 1'b1);
    check_eq("misal_a.flag", 32'(misalign_err), 32'd1);
    tick();
    check_ifid("misal_b", 32'd12, w(2), 32'd12, 1'b1);

    // 5. Halt at pc=12, stall toggling, halt+resume together, resume
    halt_req = 1'b1;
    tick();
    check_eq("halt.pc",     pc,               32'd12);
    check_eq("halt.valid",  32'(if_id_valid), 32'd0);
    check_eq("halt.halted", 32'(halted),      32'd1);
    halt_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      stall = k[0];
      tick();
      check_eq($sformatf("hold%0d.pc", k),     pc,               32'd12);
      check_eq($sformatf("hold%0d.valid", k),  32'(if_id_valid), 32'd0);
      check_eq($sformatf("hold%0d.halted", k), 32'(halted),      32'd1);
    end
    stall = 1'b0;
    halt_req = 1'b1; resume = 1'b1;
    tick();
    check_eq("halt_res.halted", 32'(halted), 32'd1);
    halt_req = 1'b0;
    tick();
    check_eq("resume.halted", 32'(halted),      32'd0);
    check_eq("resume.valid",  32'(if_id_valid), 32'd0);
    check_eq("resume.pc",     pc,               32'd12);
    resume = 1'b0;
    tick();
    check_ifid("restart", 32'd16, w(3), 32'd16, 1'b1);
    check_eq("restart.mis", 32'(misalign_err), 32'd1);

    // 6. Asynchronous reset mid-cycle during a redirect pulse
    @(negedge clk_e);
    redirect = 1'b1; redirect_pc = 32'd8;
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    tick();
    check_reset_state("rst_hold");
    reset = 1'b0;
    redirect_pc = 32'd16;
    tick();
    check_ifid("boot", 32'd4, w(0), 32'd4, 1'b1);
    redirect = 1'b0;
    tick();
    check_ifid("boot_next", 32'd8, w(1), 32'd8, 1'b1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
